// File: rtl/wb_arb_pkg.sv
// rtl/wb_arb_pkg.sv - shared types and widths for the writeback port arbiter
package wb_arb_pkg;

    localparam int REG_ID_W = 8;
    localparam int DATA_W   = 32;

    // One buffered late result waiting for the register-file write port
    typedef struct packed {
        logic [DATA_W-1:0]   data;
        logic [REG_ID_W-1:0] rd;
    } wb_entry_t;

    // Which source owns the write port this cycle
    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_PIPE,
        GNT_LATE
    } gnt_src_t;

    // Register ids at or beyond the tracked range are invisible to the scoreboard
    function automatic logic id_in_range(input logic [REG_ID_W-1:0] id, input int nregs);
        return {{(32-REG_ID_W){1'b0}}, id} < 32'(nregs);
    endfunction

endpackage

// File: rtl/wb_port_arbiter_if.sv
// rtl/wb_port_arbiter_if.sv - pipeline, late-result, decode and register-file signals
interface wb_port_arbiter_if;
    import wb_arb_pkg::*;

    logic [DATA_W-1:0]   pipe_data_in;
    logic [REG_ID_W-1:0] pipe_rd_in;
    logic                pipe_write_in;
    logic                late_valid_in;
    logic                late_ready_out;
    logic [DATA_W-1:0]   late_data_in;
    logic [REG_ID_W-1:0] late_rd_in;
    logic                issue_valid_in;
    logic [REG_ID_W-1:0] issue_rd_in;
    logic [REG_ID_W-1:0] dec_rs1_in;
    logic [REG_ID_W-1:0] dec_rs2_in;
    logic                hazard_out;
    logic                pipe_stall_out;
    logic                err_out;
    logic [DATA_W-1:0]   regs_data_out;
    logic [REG_ID_W-1:0] regs_wr_id_out;
    logic                regs_write_out;

    // Arbiter side
    modport slave (
        input  pipe_data_in, pipe_rd_in, pipe_write_in,
        input  late_valid_in, late_data_in, late_rd_in,
        input  issue_valid_in, issue_rd_in, dec_rs1_in, dec_rs2_in,
        output late_ready_out, hazard_out, pipe_stall_out, err_out,
        output regs_data_out, regs_wr_id_out, regs_write_out
    );

    // Pipeline / requester / register-file side
    modport master (
        output pipe_data_in, pipe_rd_in, pipe_write_in,
        output late_valid_in, late_data_in, late_rd_in,
        output issue_valid_in, issue_rd_in, dec_rs1_in, dec_rs2_in,
        input  late_ready_out, hazard_out, pipe_stall_out, err_out,
        input  regs_data_out, regs_wr_id_out, regs_write_out
    );

endinterface

// File: rtl/wb_late_fifo.sv
// rtl/wb_late_fifo.sv - small circular buffer holding late results
module wb_late_fifo
    import wb_arb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      push,
    input  wb_entry_t push_entry,
    input  logic      pop,
    output logic      full,
    output logic      empty,
    output wb_entry_t head
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    wb_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    // A pop frees the slot a simultaneous push needs, so full does not block it
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: occupancy decides whether head is meaningful
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_entry;
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - shares the register-file write port between writeback and late results
module wb_port_arbiter
    import wb_arb_pkg::*;
#(
    parameter int DEPTH        = 2,
    parameter int NREGS        = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    wb_port_arbiter_if.slave  bus
);

    localparam int IDX_W = (NREGS > 1) ? $clog2(NREGS) : 1;
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    wb_entry_t           push_entry;
    wb_entry_t           head;
    logic                fifo_full;
    logic                fifo_empty;
    logic                fifo_push;
    logic                fifo_pop;
    gnt_src_t            gnt;
    logic [DATA_W-1:0]   wr_data;
    logic [REG_ID_W-1:0] wr_id;
    logic [NREGS-1:0]    pending_q;
    logic [CNT_W-1:0]    starve_q;
    logic                stall_q;
    logic                err_q;

    assign push_entry = '{data: bus.late_data_in, rd: bus.late_rd_in};
    assign fifo_push  = bus.late_valid_in && !fifo_full && !reset;
    assign fifo_pop   = (gnt == GNT_LATE);

    wb_late_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (fifo_push),
        .push_entry (push_entry),
        .pop        (fifo_pop),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .head       (head)
    );

    // Pipe has priority unless a relief stall is active; nothing is granted under reset
    always_comb begin
        gnt = GNT_NONE;
        if (!reset) begin
            if (bus.pipe_write_in && !stall_q) begin
                gnt = GNT_PIPE;
            end else if (!fifo_empty) begin
                gnt = GNT_LATE;
            end
        end
    end

    // Write port mux; idle port presents zeros
    always_comb begin
        wr_data = '0;
        wr_id   = '0;
        case (gnt)
            GNT_PIPE: begin
                wr_data = bus.pipe_data_in;
                wr_id   = bus.pipe_rd_in;
            end
            GNT_LATE: begin
                wr_data = head.data;
                wr_id   = head.rd;
            end
            default: begin
                wr_data = '0;
                wr_id   = '0;
            end
        endcase
    end

    // Register 0 is hardwired, so writes to it are suppressed but still consume the grant
    assign bus.regs_write_out = (gnt != GNT_NONE) && (wr_id != '0);
    assign bus.regs_data_out  = wr_data;
    assign bus.regs_wr_id_out = wr_id;
    assign bus.late_ready_out = !fifo_full;
    assign bus.pipe_stall_out = stall_q;
    assign bus.err_out        = err_q;

    function automatic logic is_pending(input logic [REG_ID_W-1:0] id);
        return (id != '0) && id_in_range(id, NREGS) && pending_q[id[IDX_W-1:0]];
    endfunction

    assign bus.hazard_out = is_pending(bus.dec_rs1_in) | is_pending(bus.dec_rs2_in);

    // Scoreboard: clear on buffered write, set on issue; the later set wins a same-rd collision
    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q <= '0;
        end else begin
            if (gnt == GNT_LATE && id_in_range(head.rd, NREGS)) begin
                pending_q[head.rd[IDX_W-1:0]] <= 1'b0;
            end
            if (bus.issue_valid_in && bus.issue_rd_in != '0 && id_in_range(bus.issue_rd_in, NREGS)) begin
                pending_q[bus.issue_rd_in[IDX_W-1:0]] <= 1'b1;
            end
        end
    end

    // Starvation relief: count pipe wins over a waiting buffer, then force one buffer cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_q <= '0;
            stall_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            stall_q <= 1'b0;
            if (!fifo_empty && gnt == GNT_PIPE) begin
                if (starve_q == CNT_W'(STARVE_LIMIT - 1)) begin
                    starve_q <= '0;
                    stall_q  <= 1'b1;
                end else begin
                    starve_q <= starve_q + 1'b1;
                end
            end else begin
                starve_q <= '0;
            end
            if (stall_q && bus.pipe_write_in) begin
                err_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb/tb_wb_port_arbiter.sv - self-checking bench for wb_port_arbiter
module tb_wb_port_arbiter;

    localparam int DEPTH        = 2;
    localparam int NREGS        = 32;
    localparam int STARVE_LIMIT = 4;

    logic clk;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    wb_port_arbiter_if bus();

    wb_port_arbiter #(
        .DEPTH        (DEPTH),
        .NREGS        (NREGS),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        pw;
        logic [7:0]  prd;
        logic [31:0] pdata;
        logic        lv;
        logic [7:0]  lrd;
        logic [31:0] ldata;
        logic        iv;
        logic [7:0]  ird;
        logic [7:0]  rs1;
        logic [7:0]  rs2;
        logic        e_wr;
        logic [7:0]  e_id;
        logic [31:0] e_data;
        logic        e_rdy;
        logic        e_haz;
    } vec_t;

    typedef struct {
        logic [7:0]  rd;
        logic [31:0] data;
    } m_ent_t;

    m_ent_t mq[$];
    bit     m_pend[NREGS];
    int     m_starve;
    bit     m_stall;
    bit     m_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic rst, input logic pw, input logic [7:0] prd,
                                input logic [31:0] pdata, input logic lv, input logic [7:0] lrd,
                                input logic [31:0] ldata, input logic iv, input logic [7:0] ird,
                                input logic [7:0] rs1, input logic [7:0] rs2, input logic e_wr,
                                input logic [7:0] e_id, input logic [31:0] e_data,
                                input logic e_rdy, input logic e_haz);
        vec_t v;
        v.rst = rst; v.pw = pw; v.prd = prd; v.pdata = pdata;
        v.lv = lv; v.lrd = lrd; v.ldata = ldata; v.iv = iv; v.ird = ird;
        v.rs1 = rs1; v.rs2 = rs2; v.e_wr = e_wr; v.e_id = e_id; v.e_data = e_data;
        v.e_rdy = e_rdy; v.e_haz = e_haz;
        return v;
    endfunction

    task automatic set_in(input logic rst, input logic pw, input logic [7:0] prd,
                          input logic [31:0] pdata, input logic lv, input logic [7:0] lrd,
                          input logic [31:0] ldata, input logic iv, input logic [7:0] ird,
                          input logic [7:0] rs1, input logic [7:0] rs2);
        reset              = rst;
        bus.pipe_write_in  = pw;
        bus.pipe_rd_in     = prd;
        bus.pipe_data_in   = pdata;
        bus.late_valid_in  = lv;
        bus.late_rd_in     = lrd;
        bus.late_data_in   = ldata;
        bus.issue_valid_in = iv;
        bus.issue_rd_in    = ird;
        bus.dec_rs1_in     = rs1;
        bus.dec_rs2_in     = rs2;
    endtask

    task automatic idle(input logic rst);
        set_in(rst, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_vec(input vec_t v, input int idx);
        set_in(v.rst, v.pw, v.prd, v.pdata, v.lv, v.lrd, v.ldata, v.iv, v.ird, v.rs1, v.rs2);
        #2;
        chk($sformatf("vec%0d.write", idx), bus.regs_write_out, v.e_wr);
        chk($sformatf("vec%0d.id", idx), bus.regs_wr_id_out, v.e_id);
        chk($sformatf("vec%0d.data", idx), bus.regs_data_out, v.e_data);
        chk($sformatf("vec%0d.ready", idx), bus.late_ready_out, v.e_rdy);
        chk($sformatf("vec%0d.hazard", idx), bus.hazard_out, v.e_haz);
        chk($sformatf("vec%0d.stall", idx), bus.pipe_stall_out, 1'b0);
        next_cycle();
    endtask

    function automatic bit m_is_pend(input logic [7:0] id);
        if (id == 0 || int'(id) >= NREGS) return 1'b0;
        return m_pend[int'(id)];
    endfunction

    task automatic model_reset();
        mq.delete();
        foreach (m_pend[i]) m_pend[i] = 1'b0;
        m_starve = 0;
        m_stall  = 1'b0;
        m_err    = 1'b0;
    endtask

    vec_t vecs[12];

    initial begin
        logic        pgnt, lgnt, rdy, ewr;
        logic [7:0]  eid;
        logic [31:0] edata;
        logic        r_rst, r_pw, r_lv, r_iv;
        logic [7:0]  r_prd, r_lrd, r_ird, r_rs1, r_rs2;
        logic [31:0] r_pdata, r_ldata;
        bit          n_stall;

        // rst pw prd pdata lv lrd ldata iv ird rs1 rs2 | wr id data rdy haz
        vecs[0]  = mk(1, 0, 0, 0,            0, 0, 0,      0, 0,  0,  0, 0, 0, 0,            1, 0);
        vecs[1]  = mk(0, 1, 5, 32'h11223344, 0, 0, 0,      0, 0,  0,  0, 1, 5, 32'h11223344, 1, 0);
        vecs[2]  = mk(0, 0, 0, 0,            0, 0, 0,      1, 7,  7,  0, 0, 0, 0,            1, 0);
        vecs[3]  = mk(0, 0, 0, 0,            1, 7, 'hDEAD, 0, 0,  7,  0, 0, 0, 0,            1, 1);
        vecs[4]  = mk(0, 0, 0, 0,            0, 0, 0,      0, 0,  0,  7, 1, 7, 32'hDEAD,     1, 1);
        vecs[5]  = mk(0, 0, 0, 0,            0, 0, 0,      0, 0,  7,  7, 0, 0, 0,            1, 0);
        vecs[6]  = mk(0, 0, 0, 0,            1, 0, 'h55,   1, 0,  0,  0, 0, 0, 0,            1, 0);
        vecs[7]  = mk(0, 1, 0, 'h66,         0, 0, 0,      0, 0,  0,  0, 0, 0, 32'h66,       1, 0);
        vecs[8]  = mk(0, 0, 0, 0,            0, 0, 0,      0, 0,  0,  0, 0, 0, 32'h55,       1, 0);
        vecs[9]  = mk(0, 0, 0, 0,            0, 0, 0,      0, 0,  0,  0, 0, 0, 0,            1, 0);
        vecs[10] = mk(0, 0, 0, 0,            0, 0, 0,      1, 40, 40, 0, 0, 0, 0,            1, 0);
        vecs[11] = mk(0, 0, 0, 0,            0, 0, 0,      0, 0,  40, 8, 0, 0, 0,            1, 0);

        idle(1);
        next_cycle();
        next_cycle();
        #2;
        chk("reset.err", bus.err_out, 1'b0);
        chk("reset.stall", bus.pipe_stall_out, 1'b0);

        for (int i = 0; i < 12; i++) apply_vec(vecs[i], i);

        // Starvation relief and dropped pipe write during the stall
        idle(1); next_cycle();
        set_in(0, 1, 1, 32'hA0, 1, 9, 32'hB9, 0, 0, 0, 0); #2;
        chk("starve.c0.ready", bus.late_ready_out, 1'b1);
        chk("starve.c0.id", bus.regs_wr_id_out, 8'd1);
        next_cycle();
        set_in(0, 1, 2, 32'hA1, 1, 10, 32'hBA, 0, 0, 0, 0); #2;
        chk("starve.c1.ready", bus.late_ready_out, 1'b1);
        chk("starve.c1.id", bus.regs_wr_id_out, 8'd2);
        next_cycle();
        set_in(0, 1, 3, 32'hA2, 1, 11, 32'hBB, 0, 0, 0, 0); #2;
        chk("starve.full.ready", bus.late_ready_out, 1'b0);
        next_cycle();
        set_in(0, 1, 4, 32'hA3, 0, 0, 0, 0, 0, 0, 0); #2;
        chk("starve.c3.stall", bus.pipe_stall_out, 1'b0);
        next_cycle();
        set_in(0, 1, 5, 32'hA4, 0, 0, 0, 0, 0, 0, 0); #2;
        chk("starve.c4.stall", bus.pipe_stall_out, 1'b0);
        chk("starve.c4.id", bus.regs_wr_id_out, 8'd5);
        next_cycle();
        set_in(0, 1, 6, 32'hA5, 0, 0, 0, 0, 0, 0, 0); #2;
        chk("starve.c5.stall", bus.pipe_stall_out, 1'b1);
        chk("starve.c5.write", bus.regs_write_out, 1'b1);
        chk("starve.c5.id", bus.regs_wr_id_out, 8'd9);
        chk("starve.c5.data", bus.regs_data_out, 32'hB9);
        chk("starve.c5.err", bus.err_out, 1'b0);
        next_cycle();
        set_in(0, 1, 7, 32'hA6, 0, 0, 0, 0, 0, 0, 0); #2;
        chk("starve.c6.stall", bus.pipe_stall_out, 1'b0);
        chk("starve.c6.err", bus.err_out, 1'b1);
        chk("starve.c6.id", bus.regs_wr_id_out, 8'd7);
        next_cycle();
        idle(0); #2;
        chk("starve.c7.id", bus.regs_wr_id_out, 8'd10);
        chk("starve.c7.data", bus.regs_data_out, 32'hBA);
        chk("starve.c7.err", bus.err_out, 1'b1);
        next_cycle();
        #2;
        chk("starve.c8.write", bus.regs_write_out, 1'b0);
        chk("starve.c8.err", bus.err_out, 1'b1);
        idle(1); next_cycle();
        idle(0); #2;
        chk("starve.err_cleared", bus.err_out, 1'b0);

        // Same-rd issue while the buffered result for it is written: set wins
        next_cycle();
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 3, 0, 0); next_cycle();
        set_in(0, 0, 0, 0, 1, 3, 32'h33, 0, 0, 3, 0); #2;
        chk("setwin.haz_before", bus.hazard_out, 1'b1);
        next_cycle();
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 3, 3, 0); #2;
        chk("setwin.write", bus.regs_write_out, 1'b1);
        chk("setwin.id", bus.regs_wr_id_out, 8'd3);
        chk("setwin.data", bus.regs_data_out, 32'h33);
        next_cycle();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0); #2;
        chk("setwin.still_pending", bus.hazard_out, 1'b1);

        // Reset with a buffered result outstanding
        next_cycle();
        set_in(0, 0, 0, 0, 1, 4, 32'h44, 1, 4, 0, 0); next_cycle();
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); #2;
        chk("midrst.no_write", bus.regs_write_out, 1'b0);
        next_cycle();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 4, 3); #2;
        chk("midrst.hazard", bus.hazard_out, 1'b0);
        chk("midrst.write", bus.regs_write_out, 1'b0);
        chk("midrst.ready", bus.late_ready_out, 1'b1);
        next_cycle();

        // Random traffic against the reference model
        idle(1); next_cycle();
        model_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            r_rst   = ($urandom_range(0, 99) == 0);
            r_pw    = ($urandom_range(0, 99) < 60);
            r_prd   = 8'($urandom_range(0, 39));
            r_pdata = $urandom;
            r_lv    = ($urandom_range(0, 99) < 50);
            r_lrd   = 8'($urandom_range(0, 39));
            r_ldata = $urandom;
            r_iv    = ($urandom_range(0, 99) < 30);
            r_ird   = 8'($urandom_range(0, 39));
            r_rs1   = 8'($urandom_range(0, 39));
            r_rs2   = 8'($urandom_range(0, 39));
            set_in(r_rst, r_pw, r_prd, r_pdata, r_lv, r_lrd, r_ldata, r_iv, r_ird, r_rs1, r_rs2);
            #2;

            pgnt  = !r_rst && r_pw && !m_stall;
            lgnt  = !r_rst && !pgnt && (mq.size() > 0);
            rdy   = (mq.size() < DEPTH);
            eid   = pgnt ? r_prd : (lgnt ? mq[0].rd : 8'd0);
            edata = pgnt ? r_pdata : (lgnt ? mq[0].data : 32'd0);
            ewr   = (pgnt || lgnt) && (eid != 0);

            chk($sformatf("rand%0d.write", cyc), bus.regs_write_out, ewr);
            chk($sformatf("rand%0d.id", cyc), bus.regs_wr_id_out, eid);
            chk($sformatf("rand%0d.data", cyc), bus.regs_data_out, edata);
            chk($sformatf("rand%0d.ready", cyc), bus.late_ready_out, rdy);
            chk($sformatf("rand%0d.hazard", cyc), bus.hazard_out, m_is_pend(r_rs1) | m_is_pend(r_rs2));
            chk($sformatf("rand%0d.stall", cyc), bus.pipe_stall_out, m_stall);
            chk($sformatf("rand%0d.err", cyc), bus.err_out, m_err);

            if (r_rst) begin
                model_reset();
            end else begin
                n_stall = 1'b0;
                if (mq.size() > 0 && pgnt) begin
                    m_starve++;
                    if (m_starve == STARVE_LIMIT) begin
                        m_starve = 0;
                        n_stall  = 1'b1;
                    end
                end else begin
                    m_starve = 0;
                end
                if (m_stall && r_pw) m_err = 1'b1;
                m_stall = n_stall;
                if (lgnt) begin
                    if (m_is_pend(mq[0].rd) || (mq[0].rd != 0 && int'(mq[0].rd) < NREGS))
                        m_pend[int'(mq[0].rd)] = 1'b0;
                    void'(mq.pop_front());
                end
                if (r_lv && rdy) mq.push_back('{rd: r_lrd, data: r_ldata});
                if (r_iv && r_ird != 0 && int'(r_ird) < NREGS) m_pend[int'(r_ird)] = 1'b1;
            end
            next_cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the single register-file write port between the in-order writeback stage and a late-result requester, such as a multi-cycle divider or a load-miss return.
- Keeps a per-register pending scoreboard so decode can stall on operands whose late result has not been written yet.
- Sits between the writeback stage outputs (data / write id / write enable) and the register file.
- Also drives a starvation-relief stall back to the pipeline.

Parameters:
- DEPTH, 2, number of entries in the late-result buffer; power of two, at least 2.
- NREGS, 32, number of architectural registers tracked by the scoreboard.
- STARVE_LIMIT, 4, consecutive lost arbitration cycles, with the buffer non-empty, before a relief stall is requested.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- pipe_data_in  input  32  writeback data from the writeback stage.
- pipe_rd_in  input  8  destination register id from the writeback stage.
- pipe_write_in  input  1  writeback stage requests a register write.
- late_valid_in  input  1  late result offered.
- late_ready_out  output  1  buffer can accept a late result.
- late_data_in  input  32  late result data.
- late_rd_in  input  8  late result destination register.
- issue_valid_in  input  1  a late-result op is issued this cycle.
- issue_rd_in  input  8  destination register of the issued op.
- dec_rs1_in  input  8  decode operand 1 register.
- dec_rs2_in  input  8  decode operand 2 register.
- hazard_out  output  1  an operand is pending.
- pipe_stall_out  output  1  pipeline must not present a write this cycle.
- err_out  output  1  sticky protocol error.
- regs_data_out  output  32  register-file write data.
- regs_wr_id_out  output  8  register-file write id.
- regs_write_out  output  1  register-file write enable.

Behaviour:
- Reset: buffer empty, scoreboard all clear, starve counter 0, pipe_stall_out=0, err_out=0, regs_write_out=0, regs_data_out=0, regs_wr_id_out=0. late_ready_out=1 the first cycle after reset.
- Write port is combinational (0 latency) from the selected source.
  - Pipe grant: pipe_write_in=1 and pipe_stall_out=0. Write port carries pipe_* and regs_write_out=1.
  - Buffer grant: no pipe grant and buffer non-empty. Write port carries the buffer head, the head is popped at the clock edge, and the scoreboard bit for the head rd is cleared.
  - Otherwise regs_write_out=0 and data/id are held at 0.
- rd 0: any write whose id is 0 gives regs_write_out=0. A buffer entry with rd 0 is still popped. Issue with rd 0 never sets a scoreboard bit.
- Late handshake: a transfer occurs when late_valid_in and late_ready_out are both 1. late_ready_out = !full; it does not depend on late_valid_in.
- Push and pop in the same cycle are allowed when full; occupancy is unchanged. Pointers wrap modulo DEPTH.
- Scoreboard:
  - Bit set on issue_valid_in at the clock edge; cleared on buffer grant.
  - Same rd set and cleared in one cycle: set wins.
  - Ids >= NREGS are ignored for set, clear and query.
- hazard_out is combinational: (pending[rs1] & rs1!=0) | (pending[rs2] & rs2!=0).
- Starvation counter:
  - Increments each cycle the buffer is non-empty and the pipe is granted.
  - Resets to 0 on any buffer grant or when the buffer is empty.
  - Reaching STARVE_LIMIT registers pipe_stall_out=1 for exactly the next cycle; the counter returns to 0.
- During pipe_stall_out=1 the buffer is always granted. If pipe_write_in=1 in that cycle, the pipe write is dropped and err_out sets; err_out clears only on reset.
- Reset mid-operation: buffered results are discarded, the scoreboard is cleared, and no write is issued in the reset cycle.

Decomposition:
- Shared package wb_arb_pkg holds:
  - the buffer entry struct (data 32, rd 8);
  - grant source enum {GNT_NONE, GNT_PIPE, GNT_LATE};
  - the register id width constant.
- One sub-module, wb_late_fifo: DEPTH-entry FIFO with push/pop, full/empty outputs and head entry output. Arbitration, scoreboard and starvation logic stay in the top module.

Test Plan:
- Reset, then pipe_write_in=1, rd=5, data=0x11223344 -> same cycle: regs_write_out=1, id 5, data 0x11223344. late_ready_out=1.
- Issue rd=7, then late result rd=7, data=0xDEAD with the pipe idle:
  - hazard_out=1 for rs1=7 from the cycle after issue;
  - the write (7, 0xDEAD) occurs the cycle after acceptance;
  - hazard_out=0 after that write.
- Fill the buffer (2 entries) while the pipe writes every cycle -> late_ready_out=0. After 4 lost cycles pipe_stall_out=1 for one cycle and the head entry is written in that cycle.
- Assert pipe_write_in during pipe_stall_out=1 -> the buffer entry is written, the pipe write is dropped, err_out=1 and stays 1 until reset.
- Issue rd=3 in the same cycle the buffered rd=3 result is written -> the write happens and pending[3] remains 1.
- Late result to rd=0 and pipe write to rd=0 -> regs_write_out=0 in both cases, the buffer drains, hazard_out never asserts for rs=0.
